// File: rtl/dm_store_buffer_pkg.sv
// Shared definitions for the data-memory store buffer.
//   BE_W / BYTE_W : byte-lane count and lane width of a DM word
//   sb_entry_t    : one buffered store (pc, addr, data, be)
//   word_idx()    : word index of a byte address, used for forwarding matches
package dm_store_buffer_pkg;

  localparam int BE_W   = 4;
  localparam int BYTE_W = 8;

  typedef struct packed {
    logic [31:0]     pc;
    logic [31:0]     addr;
    logic [31:0]     data;
    logic [BE_W-1:0] be;
  } sb_entry_t;

  function automatic logic [29:0] word_idx(input logic [31:0] addr);
    return addr[31:2];
  endfunction

endpackage

// File: rtl/dm_store_fwd_match.sv
// Store-to-load forwarding match for the store buffer. Purely combinational.
// Ports:
//   entries     : physical entry array
//   rd_ptr      : index of the oldest pending entry
//   count       : number of pending entries
//   ld_addr     : load byte address
//   ld_fwd_mask : lanes supplied by the buffer
//   ld_fwd_data : forwarded lanes, 0 where the mask is clear
module dm_store_fwd_match
  import dm_store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  sb_entry_t          entries [DEPTH],
  input  logic [PTR_W-1:0]   rd_ptr,
  input  logic [PTR_W:0]     count,
  input  logic [31:0]        ld_addr,
  output logic [BE_W-1:0]    ld_fwd_mask,
  output logic [31:0]        ld_fwd_data
);

  localparam int CW = PTR_W + 1;

  // Entries re-ordered by age: slot 0 is the oldest, slot count-1 the youngest.
  // Working in age order makes "youngest wins" independent of pointer wrap.
  sb_entry_t        aged [DEPTH];
  logic [DEPTH-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_age
      assign aged[gi] = entries[rd_ptr + PTR_W'(gi)];
      assign hit[gi]  = (CW'(gi) < count) &&
                        (word_idx(aged[gi].addr) == word_idx(ld_addr));
    end

    for (gi = 0; gi < BE_W; gi++) begin : g_lane
      logic              lane_hit;
      logic [BYTE_W-1:0] lane_byte;

      // Scan oldest to youngest so a younger match overrides an older one.
      always_comb begin
        lane_hit  = 1'b0;
        lane_byte = '0;
        for (int k = 0; k < DEPTH; k++) begin
          if (hit[k] && aged[k].be[gi]) begin
            lane_hit  = 1'b1;
            lane_byte = aged[k].data[gi*BYTE_W +: BYTE_W];
          end
        end
      end

      assign ld_fwd_mask[gi]                   = lane_hit;
      assign ld_fwd_data[gi*BYTE_W +: BYTE_W]  = lane_byte;
    end
  endgenerate

endmodule

// File: rtl/dm_store_buffer.sv
// Posted-store buffer in front of the data memory write port.
// Stores are queued in order and drained one per cycle when drain_en grants a
// DM slot; loads get forwarded bytes from any pending store to the same word.
// Ports:
//   clk, reset                   : clock, asynchronous active-high reset
//   st_valid/st_ready            : store handshake
//   st_pc/st_addr/st_data/st_be  : store payload
//   drain_en                     : DM write slot available this cycle
//   dm_we/dm_pc/dm_addr/dm_wdata/dm_be : head entry towards the DM
//   ld_addr                      : load address to check
//   ld_fwd_mask/ld_fwd_data      : forwarded lanes
//   empty                        : nothing pending
module dm_store_buffer
  import dm_store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            st_valid,
  output logic            st_ready,
  input  logic [31:0]     st_pc,
  input  logic [31:0]     st_addr,
  input  logic [31:0]     st_data,
  input  logic [BE_W-1:0] st_be,
  input  logic            drain_en,
  output logic            dm_we,
  output logic [31:0]     dm_pc,
  output logic [31:0]     dm_addr,
  output logic [31:0]     dm_wdata,
  output logic [BE_W-1:0] dm_be,
  input  logic [31:0]     ld_addr,
  output logic [BE_W-1:0] ld_fwd_mask,
  output logic [31:0]     ld_fwd_data,
  output logic            empty
);

  localparam int CW = PTR_W + 1;

  logic [31:0]     pc_mem   [DEPTH];
  logic [31:0]     addr_mem [DEPTH];
  logic [31:0]     data_mem [DEPTH];
  logic [BE_W-1:0] be_reg   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;

  logic push;
  logic pop;

  sb_entry_t entries [DEPTH];

  // A full buffer refuses a push even when it drains in the same cycle.
  assign st_ready = (count_reg != CW'(DEPTH));
  assign empty    = (count_reg == '0);
  assign push     = st_valid & st_ready;
  assign dm_we    = ~empty & drain_en;
  assign pop      = dm_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        be_reg[i] <= '0;
      end
    end else begin
      if (push) begin
        be_reg[wr_ptr_reg] <= st_be;
        wr_ptr_reg         <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Payload fields need no reset: an entry is only observed while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]   <= st_pc;
      addr_mem[wr_ptr_reg] <= st_addr;
      data_mem[wr_ptr_reg] <= st_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign entries[gi] = {pc_mem[gi], addr_mem[gi], data_mem[gi], be_reg[gi]};
    end
  endgenerate

  assign dm_pc    = entries[rd_ptr_reg].pc;
  assign dm_addr  = entries[rd_ptr_reg].addr;
  assign dm_wdata = entries[rd_ptr_reg].data;
  assign dm_be    = entries[rd_ptr_reg].be;

  dm_store_fwd_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fwd (
    .entries     (entries),
    .rd_ptr      (rd_ptr_reg),
    .count       (count_reg),
    .ld_addr     (ld_addr),
    .ld_fwd_mask (ld_fwd_mask),
    .ld_fwd_data (ld_fwd_data)
  );

endmodule

// File: doc/dm_store_buffer.md
Name: dm_store_buffer

Overview:
- Posted-store buffer placed directly upstream of the data memory. It accepts byte-enabled stores from the execute/memory stage and drains them in order into the DM write port, at most one per cycle, when the DM grants a slot.
- Loads check the buffer combinationally and receive forwarded bytes for any pending store to the same word. The consumer merges these bytes over the DM read data.
- Decouples store issue from DM write availability.

Parameters:
- DEPTH, 4: number of entries; power of two, at least 2.
- PTR_W, 2: log2(DEPTH); pointer width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- st_valid  input  1  store request
- st_ready  output  1  buffer can accept a store this cycle
- st_pc  input  32  PC of the store, carried for the trace
- st_addr  input  32  byte address; word = st_addr[31:2]
- st_data  input  32  store data, lanes already aligned
- st_be  input  4  byte enables, bit i = byte lane i
- drain_en  input  1  DM grants a write slot this cycle
- dm_we  output  1  DM write strobe
- dm_pc  output  32  head entry PC
- dm_addr  output  32  head entry address
- dm_wdata  output  32  head entry data
- dm_be  output  4  head entry byte enables
- ld_addr  input  32  load byte address to check
- ld_fwd_mask  output  4  lanes supplied by the buffer
- ld_fwd_data  output  32  forwarded lanes; lanes not in the mask are 0
- empty  output  1  no pending stores, for fence/halt

Behaviour:
- State: entry array, wr_ptr and rd_ptr (PTR_W bits, natural wrap), count (PTR_W+1 bits, range 0..DEPTH).
- Reset (asynchronous, dominant over everything):
  - count, wr_ptr, rd_ptr = 0; all entry be fields = 0.
  - Outputs settle to st_ready = 1, empty = 1, dm_we = 0, ld_fwd_mask = 0.
  - A reset asserted mid-operation discards all pending stores; none are written.
- Combinational outputs:
  - st_ready = (count != DEPTH). There is no full-bypass: a full buffer refuses a push even if it drains in the same cycle.
  - push = st_valid & st_ready.
  - dm_we = (count != 0) & drain_en; pop = dm_we.
  - dm_* fields come from the entry at rd_ptr. Their values are don't-care when empty, but dm_we = 0 then.
  - empty = (count == 0).
- Sequential, on the clk edge:
  - push: write the entry at wr_ptr, then wr_ptr + 1.
  - pop: rd_ptr + 1.
  - count updates by +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: a store pushed at edge N is presented on dm_* during cycle N+1 at the earliest.
- Ordering: strictly FIFO; no write combining, no reordering.
- st_be = 0: accepted and drained as an entry with dm_be = 0, a no-op write.
- Forwarding:
  - Compare ld_addr[31:2] against every valid entry.
  - Per lane, the youngest matching entry with that lane's be bit set supplies the byte.
  - ld_fwd_mask = OR of the supplying lanes.
  - The head entry being drained in the current cycle still forwards, because the DM has not yet updated.
  - A store being pushed in the current cycle does not forward; the pipeline resolves that hazard.
- Wrap-around: pointers wrap modulo DEPTH. Youngest-first priority is computed from relative age (index - rd_ptr mod DEPTH), not from physical index.
- The buffer does not print a trace; the DM emits the write trace using dm_pc.

Decomposition:
- Shared package/header holds:
  - BE_W = 4 and the lane-byte width 8.
  - The entry record layout (pc, addr, data, be).
  - The word-index slice [31:2].
- One sub-module, dm_store_fwd_match: purely combinational, taking the entry array, rd_ptr, count and ld_addr, and returning ld_fwd_mask and ld_fwd_data.
- The FIFO control stays in the parent.

Test Plan:
- Reset then idle: empty=1, st_ready=1, dm_we=0, ld_fwd_mask=0 for any ld_addr.
- Single store: addr=0x0000_0010, data=0xDEAD_BEEF, be=0xF, drain_en=0 for 3 cycles, then 1 → expected:
  - dm_we stays 0 while drain_en=0.
  - dm_we=1 for exactly 1 cycle with addr 0x10, data 0xDEADBEEF, be 0xF.
  - empty=1 afterwards.
- Fill to DEPTH=4 with drain_en=0: st_ready drops after the 4th push. A 5th st_valid is not accepted. With drain_en=1, the 4 entries drain in push order over 4 consecutive cycles, and st_ready returns after the first pop.
- Forwarding:
  - Push sw 0x1111_1111 to 0x20, then sb lane 2 data 0x00AA_0000 to 0x22. Load 0x20 → mask=0xF, data=0x11AA_1111.
  - Load 0x24 → mask=0x0.
- Simultaneous push/pop at count=2 for 6 cycles with pointers wrapping: count stays 2, and drained addresses match push order exactly.
- Assert reset asynchronously, between clock edges, with 3 entries pending: dm_we=0 and empty=1 immediately, and no pending entry is ever written afterwards.
